// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial stimulus generator.
// Holds the FSM state encoding and the reference pattern defaults.
package seq_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int         PAT_LEN_DEF = 4;
    localparam logic [3:0] PATTERN_DEF = 4'b1011;
    localparam int         CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_ref_matcher.sv
// Reference sequence matcher on the transmitted serial stream.
// Produces the expected-detection strobe and a saturating match count.
module seq_ref_matcher
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_out,
    input  logic             ser_valid,
    output logic             exp_det,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int HW = PAT_LEN - 1;
    localparam int VW = $clog2(PAT_LEN);

    logic [HW-1:0]      hist;
    logic [VW-1:0]      vcnt;
    logic [PAT_LEN-1:0] win;
    logic               full;
    logic               hit;

    assign win  = {hist, ser_out};
    assign full = (vcnt == VW'(HW));
    assign hit  = ser_valid && full && (win == PATTERN);

    // vcnt counts fresh history bits so a cleared history cannot match early
    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            vcnt      <= '0;
            exp_det   <= 1'b0;
            match_cnt <= '0;
        end else begin
            exp_det <= hit;
            if (hit && match_cnt != '1)
                match_cnt <= match_cnt + 1'b1;
            if (!ser_valid) begin
                hist <= '0;
                vcnt <= '0;
            end else if (hit && OVERLAP == 0) begin
                hist <= '0;
                vcnt <= '0;
            end else begin
                hist <= win[HW-1:0];
                if (!full)
                    vcnt <= vcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_stream_gen.sv
// Parallel-to-serial stimulus transmitter with valid/ready load port.
// Shifts words out MSB-first and runs a reference matcher alongside.
module seq_stream_gen
    import seq_pkg::*;
#(
    parameter int                 WIDTH   = 16,
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             exp_det,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int            BW   = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-2:0] sreg;
    logic [BW-1:0]    bcnt;
    logic             accept;

    // Ready in the last-bit cycle lets words run back to back
    assign load_ready = !rst &&
        (state == IDLE || (state == SHIFT && bcnt == '0));
    assign accept = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            bcnt      <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            sreg      <= load_data[WIDTH-2:0];
            bcnt      <= LAST;
            ser_out   <= load_data[WIDTH-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
        end else if (state == SHIFT) begin
            if (bcnt == '0) begin
                state     <= IDLE;
                ser_out   <= 1'b0;
                ser_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                bcnt    <= bcnt - 1'b1;
                ser_out <= sreg[WIDTH-2];
                sreg    <= sreg << 1;
            end
        end
    end

    seq_ref_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .CNT_W   (CNT_W)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .exp_det   (exp_det),
        .match_cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_stream_gen.sv
// Directed bench for seq_stream_gen: three instances share the load port
// (overlap, non-overlap, 2-bit counter) and are traced per cycle.
module tb_seq_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;

    logic       rdy_a, ser_a, val_a, exp_a, busy_a;
    logic [7:0] cnt_a;
    logic       rdy_b, ser_b, val_b, exp_b, busy_b;
    logic [7:0] cnt_b;
    logic       rdy_c, ser_c, val_c, exp_c, busy_c;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;

    logic        tser [0:63];
    logic        tval [0:63];
    logic        trdy [0:63];
    logic [63:0] mask_a;
    logic [63:0] mask_b;
    logic [15:0] serw;
    int          nval;
    int          nexp_c;

    always #5 clk = ~clk;

    seq_stream_gen #(.OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .load_valid(load_valid),
        .load_data(load_data), .load_ready(rdy_a),
        .ser_out(ser_a), .ser_valid(val_a), .exp_det(exp_a),
        .match_cnt(cnt_a), .busy(busy_a)
    );

    seq_stream_gen #(.OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .load_valid(load_valid),
        .load_data(load_data), .load_ready(rdy_b),
        .ser_out(ser_b), .ser_valid(val_b), .exp_det(exp_b),
        .match_cnt(cnt_b), .busy(busy_b)
    );

    seq_stream_gen #(.OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .load_valid(load_valid),
        .load_data(load_data), .load_ready(rdy_c),
        .ser_out(ser_c), .ser_valid(val_c), .exp_det(exp_c),
        .match_cnt(cnt_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Accept edge is cycle 0; traces cycles 1..n sampled 1 time unit after each edge
    task automatic run(input logic [15:0] w1, input bit two,
                       input int gap, input logic [15:0] w2,
                       input int n);
        mask_a = '0;
        mask_b = '0;
        nval   = 0;
        serw   = '0;
        for (int i = 0; i < 64; i++) begin
            tser[i] = 1'b0;
            tval[i] = 1'b0;
            trdy[i] = 1'b0;
        end
        @(negedge clk);
        chk("ready_before_accept", 64'(rdy_a), 64'd1);
        load_valid = 1'b1;
        load_data  = w1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 16'($urandom);
        for (int c = 1; c <= n; c++) begin
            if (two && c == 17 + gap)
                load_valid = 1'b0;
            tser[c] = ser_a;
            tval[c] = val_a;
            trdy[c] = rdy_a;
            if (val_a) nval++;
            if (exp_a) mask_a[c] = 1'b1;
            if (exp_b) mask_b[c] = 1'b1;
            if (exp_c) nexp_c++;
            if (c <= 16) serw[16-c] = ser_a;
            if (two && c == 16 + gap) begin
                load_valid = 1'b1;
                load_data  = w2;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        nexp_c     = 0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ser_valid", 64'(val_a), 64'd0);
        chk("rst_exp_det", 64'(exp_a), 64'd0);
        chk("rst_match_cnt", 64'(cnt_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_ser_out", 64'(ser_a), 64'd0);
        chk("rst_load_ready", 64'(rdy_a), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(rdy_a), 64'd1);

        // Single word D6B5, overlapping
        run(16'hD6B5, 1'b0, 0, 16'h0, 18);
        chk("d6b5_bits", 64'(serw), 64'hD6B5);
        chk("d6b5_exp", mask_a, 64'h2100);
        chk("d6b5_cnt", 64'(cnt_a), 64'd2);
        chk("d6b5_nval", 64'(nval), 64'd16);
        chk("d6b5_rdy15", 64'(trdy[15]), 64'd0);
        chk("d6b5_rdy16", 64'(trdy[16]), 64'd1);
        chk("d6b5_val17", 64'(tval[17]), 64'd0);

        // B600 under both overlap settings
        do_reset();
        run(16'hB600, 1'b0, 0, 16'h0, 18);
        chk("b600_ov1_exp", mask_a, 64'h120);
        chk("b600_ov1_cnt", 64'(cnt_a), 64'd2);
        chk("b600_ov0_exp", mask_b, 64'h20);
        chk("b600_ov0_cnt", 64'(cnt_b), 64'd1);

        // 0005 then 8000 back to back: cross-boundary match
        do_reset();
        run(16'h0005, 1'b1, 0, 16'h8000, 34);
        chk("b2b_nval", 64'(nval), 64'd32);
        chk("b2b_val17", 64'(tval[17]), 64'd1);
        chk("b2b_bit17", 64'(tser[17]), 64'd1);
        chk("b2b_exp", mask_a, 64'h1 << 18);
        chk("b2b_cnt", 64'(cnt_a), 64'd1);

        // Same words with a one-cycle gap: stream broken
        do_reset();
        run(16'h0005, 1'b1, 1, 16'h8000, 35);
        chk("gap_nval", 64'(nval), 64'd32);
        chk("gap_val17", 64'(tval[17]), 64'd0);
        chk("gap_exp", mask_a, 64'h0);
        chk("gap_cnt", 64'(cnt_a), 64'd0);

        // Reset at the edge ending cycle 5 of a shift
        do_reset();
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'hD6B5;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy_c5", 64'(busy_a), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ser_valid", 64'(val_a), 64'd0);
        chk("mid_exp_det", 64'(exp_a), 64'd0);
        chk("mid_match_cnt", 64'(cnt_a), 64'd0);
        chk("mid_load_ready", 64'(rdy_a), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_ready_after", 64'(rdy_a), 64'd1);
        run(16'hD6B5, 1'b0, 0, 16'h0, 18);
        chk("mid_resend_bits", 64'(serw), 64'hD6B5);
        chk("mid_resend_exp", mask_a, 64'h2100);
        chk("mid_resend_cnt", 64'(cnt_a), 64'd2);

        // Idle with random data and no valid
        nval = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_data  = 16'($urandom);
            @(posedge clk);
            #1;
            if (val_a) nval++;
        end
        chk("idle_nval", 64'(nval), 64'd0);
        chk("idle_cnt", 64'(cnt_a), 64'd2);

        // Saturation of a 2-bit counter over four separated words
        do_reset();
        nexp_c = 0;
        for (int w = 0; w < 4; w++)
            run(16'hD6B5, 1'b0, 0, 16'h0, 18);
        chk("sat_pulses", 64'(nexp_c), 64'd8);
        chk("sat_cnt_c", 64'(cnt_c), 64'd3);
        chk("sat_cnt_a", 64'(cnt_a), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_stream_gen.md
# seq_stream_gen

Serial stimulus transmitter for the sequence-detector path. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a serial line that drives a detector's `in` port. In parallel it runs a reference matcher on the transmitted bits and produces an expected-detection strobe and a match count, so a bench or a self-check can compare against the detector's `detected` output cycle by cycle.

## Interface
- `WIDTH`, 16: parallel word width; must be ≥ `PAT_LEN`.
- `PAT_LEN`, 4: target pattern length, 2..8.
- `PATTERN`, 4'b1011: target sequence; its MSB is the first bit in time.
- `OVERLAP`, 1: 1 = overlapping matching, 0 = non-overlapping.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `load_valid  in  1`: a parallel word is offered.
- `load_data  in  WIDTH`: the word to transmit, MSB first.
- `load_ready  out  1`: the block can accept a word this cycle.
- `ser_out  out  1`: serial bit, registered.
- `ser_valid  out  1`: `ser_out` carries a transmitted bit this cycle.
- `exp_det  out  1`: one-cycle strobe for the expected detection.
- `match_cnt  out  CNT_W`: saturating count of matches since reset.
- `busy  out  1`: the block is in SHIFT.

## Operation
- Moore FSM with two states.
  - IDLE: `ser_valid` = 0.
  - SHIFT: `ser_valid` = 1, bit counter `bcnt` runs from WIDTH-1 down to 0.
- `load_ready` = !rst && (IDLE || (SHIFT && bcnt == 0)). This allows back-to-back words with no gap.
- A word is accepted when `load_valid && load_ready` at an edge.
  - The shift register is loaded.
  - `bcnt` is set to WIDTH-1.
  - The state goes to SHIFT.
- SHIFT with `bcnt` == 0 and no accept: the state goes to IDLE.
- `load_data` is ignored when no handshake occurs. A word is never partially overwritten.
- Reference matcher:
  - Keeps a history register `hist` of the last PAT_LEN-1 transmitted bits.
  - At every edge where `ser_valid` = 1, it forms the window {hist, ser_out}.
  - If the window equals PATTERN, then on the next cycle `exp_det` = 1 and `match_cnt` increments, saturating at 2^CNT_W-1.
  - `hist` then shifts in `ser_out`.
  - If OVERLAP = 0, `hist` is cleared to all zeros after a match instead of shifting. A leading zero in the cleared history can never complete a pattern early, because the window needs PAT_LEN fresh bits; a valid-bit counter in the matcher enforces this.
- Bit continuity:
  - `hist` and its valid-bit counter persist across back-to-back words, so matches spanning a word boundary are found.
  - Both are cleared on any cycle with `ser_valid` = 0, so an idle gap breaks the stream.
- Reset (`rst` high at an edge) forces the following, regardless of state:
  - state = IDLE
  - `ser_out` = 0, `ser_valid` = 0, `exp_det` = 0, `busy` = 0
  - `match_cnt` = 0, `hist` = 0
  - Any in-flight word is dropped.

## Timing
- Accept edge = cycle 0. Bit k (k = 0 is the MSB) appears on `ser_out` in cycle k+1.
- `exp_det` for a pattern completed by bit k is asserted in cycle k+2. This matches a registered Moore detector fed by `ser_out`.
- Back-to-back words give WIDTH·n consecutive `ser_valid` cycles. `load_ready` is high only in the last-bit cycle of each word.
- `load_ready` is 0 while `rst` = 1. It is 1 from the first cycle after `rst` deasserts.
- Simultaneous accept and last bit: the last bit is still transmitted, and the new MSB follows in the next cycle.

## Structure
- Package `seq_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - the default PATTERN and PAT_LEN constants;
  - the CNT_W default.
- Sub-module `seq_ref_matcher` contains the history register, the valid-bit counter, the compare, the OVERLAP handling, `exp_det` and `match_cnt`.
- The top level contains the FSM, the shift register and the handshake.

## Test plan
- Send one word, 16'hD6B5, OVERLAP = 1.
  - `ser_out` carries 1101011010110101 in cycles 1..16.
  - `exp_det` pulses in cycles 8 and 13.
  - `match_cnt` = 2.
  - `load_ready` is high again in cycle 16.
- Send 16'hB600 (bits 1011011…) under both settings.
  - OVERLAP = 1: `exp_det` in cycles 5 and 8; `match_cnt` = 2.
  - OVERLAP = 0: `exp_det` in cycle 5 only; `match_cnt` = 1.
- Send 16'h0005 and then 16'h8000 back-to-back.
  - 32 continuous `ser_valid` cycles.
  - A cross-boundary match gives `exp_det` in cycle 18.
  - Repeating with a one-cycle gap between the words gives no match.
- Assert `rst` at the edge ending cycle 5 of a shift of 16'hD6B5.
  - Next cycle: `ser_valid` = 0, `exp_det` = 0, `match_cnt` = 0, `load_ready` = 0.
  - After `rst` falls, `load_ready` = 1, and a new word transmits cleanly.
- Hold `load_valid` = 0 with random `load_data` for 20 cycles: `ser_valid` stays 0 and `match_cnt` is unchanged.
- Set CNT_W = 2 and send four words of 16'hD6B5: `match_cnt` saturates at 3, while `exp_det` still pulses 8 times.
